uart_transmitter: RTL and testbench



---
 rtl/uart_transmitter.sv | 100 ++++++++++
 tb/tb_uart_transmitter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// uart_transmitter: FIFO-buffered UART transmitter, LSB-first frames with optional parity.
module uart_transmitter #(
   parameter int CLK_HZ     = 50000000,
   parameter int BAUD       = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DATA_BITS-1:0]          data,
   input  logic                          valid,
   output logic                          ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   level
);
   localparam int CPB = (CLK_HZ + BAUD / 2) / BAUD;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int LW  = AW + 1;
   localparam int CW  = $clog2(CPB);
   localparam logic [LW-1:0] FULL      = LW'(FIFO_DEPTH);
   localparam logic [CW-1:0] CNT_MAX   = CW'(CPB - 1);
   localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);
   localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
   state_t               r_state;
   logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]        r_wr, r_rd;
   logic [LW-1:0]        r_level;
   logic [DATA_BITS-1:0] r_shift;
   logic [CW-1:0]        r_cnt;
   logic [2:0]           r_bit;
   logic                 r_par, r_tx;
   logic                 w_push, w_pop, w_tick;
   assign ready  = r_level != FULL;
   assign w_push = valid && ready;
   assign w_pop  = (r_state == S_IDLE) && (r_level != '0);
   assign w_tick = r_cnt == CNT_MAX;
   assign tx     = r_tx;
   assign level  = r_level;
   assign busy   = (r_state != S_IDLE) || (r_level != '0);
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= data;
   end
   // r_bit indexes data bits in DATA and stop bits in STOP
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_wr    <= '0;
         r_rd    <= '0;
         r_level <= '0;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_par   <= 1'b0;
         r_tx    <= 1'b1;
      end else begin
         r_wr    <= r_wr + AW'(w_push);
         r_rd    <= r_rd + AW'(w_pop);
         r_level <= r_level + LW'(w_push) - LW'(w_pop);
         r_cnt   <= (r_state == S_IDLE || w_tick) ? '0 : r_cnt + CW'(1);
         case (r_state)
            S_IDLE: if (w_pop) begin
               r_shift <= r_mem[r_rd];
               r_par   <= (PARITY == 2) ? ~^r_mem[r_rd] : ^r_mem[r_rd];
               r_tx    <= 1'b0;
               r_state <= S_START;
            end
            S_START: if (w_tick) begin
               r_tx    <= r_shift[0];
               r_shift <= r_shift >> 1;
               r_bit   <= '0;
               r_state <= S_DATA;
            end
            S_DATA: if (w_tick) begin
               if (r_bit == BIT_LAST) begin
                  r_bit   <= '0;
                  r_tx    <= (PARITY != 0) ? r_par : 1'b1;
                  r_state <= (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  r_tx    <= r_shift[0];
                  r_shift <= r_shift >> 1;
                  r_bit   <= r_bit + 3'd1;
               end
            end
            S_PARITY: if (w_tick) begin
               r_tx    <= 1'b1;
               r_state <= S_STOP;
            end
            S_STOP: if (w_tick) begin
               r_bit   <= (r_bit == STOP_LAST) ? 3'd0 : r_bit + 3'd1;
               r_state <= (r_bit == STOP_LAST) ? S_IDLE : S_STOP;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: scoreboard bench; a serial monitor decodes tx and checks against accepted bytes.
module tb_uart_transmitter;
   logic       clk = 1'b0, rst = 1'b1, skip = 1'b0;
   logic [7:0] data0 = '0, data1 = '0;
   logic       valid0 = 1'b0, valid1 = 1'b0;
   logic       ready0, tx0, busy0, ready1, tx1, busy1;
   logic [2:0] level0, level1;
   int         n_checks = 0, n_fail = 0;
   logic [7:0] q0[$], q1[$];
   time        st0[$];
   always #5 clk = ~clk;
   uart_transmitter #(.CLK_HZ(1000), .BAUD(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
      .clk(clk), .rst(rst), .data(data0), .valid(valid0), .ready(ready0), .tx(tx0), .busy(busy0), .level(level0));
   uart_transmitter #(.CLK_HZ(1000), .BAUD(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut1 (
      .clk(clk), .rst(rst), .data(data1), .valid(valid1), .ready(ready1), .tx(tx1), .busy(busy1), .level(level1));
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   // handshake observer: every accepted byte becomes an expected frame
   always @(posedge clk) begin
      if (!rst && valid0 && ready0) q0.push_back(data0);
      if (!rst && valid1 && ready1) q1.push_back(data1);
   end
   always @(negedge clk) if (!rst) check("level_bound", {31'd0, level0 <= 3'd4 && level1 <= 3'd4}, 1);
   function automatic logic txs(input int id);
      return (id == 0) ? tx0 : tx1;
   endfunction
   task automatic monitor(input int id, input int par, input int nstop);
      logic [7:0] exp, d;
      logic       have;
      forever begin
         if (id == 0) @(negedge tx0); else @(negedge tx1);
         if (id == 0) st0.push_back($time);
         have = 1'b0;
         exp  = '0;
         d    = '0;
         if (!skip) begin
            if (id == 0 && q0.size() > 0) begin exp = q0.pop_front(); have = 1'b1; end
            else if (id == 1 && q1.size() > 0) begin exp = q1.pop_front(); have = 1'b1; end
            else begin
               n_checks++;
               n_fail++;
               $display("FAIL mon%0d_unexpected_frame: got frame expected none", id);
            end
         end
         repeat (5) @(posedge clk);
         #1 if (!skip) check($sformatf("mon%0d_start", id), {31'd0, txs(id)}, 0);
         for (int i = 0; i < 8; i++) begin
            repeat (10) @(posedge clk);
            #1 d[i] = txs(id);
         end
         if (par != 0) begin
            repeat (10) @(posedge clk);
            #1 if (!skip && have) check($sformatf("mon%0d_parity", id), {31'd0, txs(id)}, {31'd0, (par == 1) ? ^exp : ~^exp});
         end
         for (int s = 0; s < nstop; s++) begin
            repeat (10) @(posedge clk);
            #1 if (!skip) check($sformatf("mon%0d_stop", id), {31'd0, txs(id)}, 1);
         end
         if (!skip && have) check($sformatf("mon%0d_data", id), {24'd0, d}, {24'd0, exp});
      end
   endtask
   initial monitor(0, 0, 1);
   initial monitor(1, 1, 2);
   task automatic send(input int id, input logic [7:0] b);
      int   t = 0;
      logic acc = 1'b0;
      while (!acc && t < 1000) begin
         @(negedge clk);
         if (id == 0) begin data0 = b; valid0 = 1'b1; acc = ready0; end
         else begin data1 = b; valid1 = 1'b1; acc = ready1; end
         @(posedge clk);
         t++;
      end
      #1;
      valid0 = 1'b0;
      valid1 = 1'b0;
      if (!acc) check($sformatf("send%0d_timeout", id), 0, 1);
   endtask
   task automatic wait_idle(input int id);
      int t = 0;
      while (((id == 0) ? busy0 : busy1) !== 1'b0 && t < 5000) begin
         @(posedge clk);
         t++;
      end
      if (t >= 5000) check($sformatf("idle%0d_timeout", id), {31'd0, (id == 0) ? busy0 : busy1}, 0);
      repeat (3) @(posedge clk);
      #1;
   endtask
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   logic [7:0] vec [12] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h81, 8'h7E, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
   initial begin
      logic [9:0]  fr10;
      logic [11:0] fr12;
      int          errs, cur, e, chg;
      logic        acc;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx0", {31'd0, tx0}, 1);
      check("rst_busy0", {31'd0, busy0}, 0);
      check("rst_level0", {29'd0, level0}, 0);
      check("rst_ready0", {31'd0, ready0}, 1);
      check("rst_tx1", {31'd0, tx1}, 1);
      @(negedge clk) rst = 1'b0;
      // 8N1 frame for 0xA5, cycle-exact
      fr10 = {1'b1, 8'hA5, 1'b0};
      errs = 0;
      send(0, 8'hA5);
      check("t1_level_after_push", {29'd0, level0}, 1);
      check("t1_tx_idle_at_n", {31'd0, tx0}, 1);
      check("t1_busy_at_n", {31'd0, busy0}, 1);
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk);
         #1 if (tx0 !== fr10[(k - 1) / 10]) errs++;
         if (k == 1) check("t1_level_after_pop", {29'd0, level0}, 0);
      end
      check("t1_waveform", errs, 0);
      check("t1_busy_n100", {31'd0, busy0}, 1);
      @(posedge clk);
      #1 check("t1_busy_n101", {31'd0, busy0}, 0);
      check("t1_tx_n101", {31'd0, tx0}, 1);
      // even parity, two stop bits, 0x07
      fr12 = {2'b11, 1'b1, 8'h07, 1'b0};
      errs = 0;
      send(1, 8'h07);
      for (int k = 1; k <= 120; k++) begin
         @(posedge clk);
         #1 if (tx1 !== fr12[(k - 1) / 10]) errs++;
      end
      check("t2_waveform", errs, 0);
      check("t2_busy_n120", {31'd0, busy1}, 1);
      @(posedge clk);
      #1 check("t2_busy_n121", {31'd0, busy1}, 0);
      send(1, 8'h03);
      wait_idle(1);
      // held valid into a depth-4 FIFO
      wait_idle(0);
      st0.delete();
      cur = 1;
      e = 0;
      @(negedge clk);
      while (cur <= 6 && e < 500) begin
         data0 = 8'(cur);
         valid0 = 1'b1;
         acc = ready0;
         @(posedge clk);
         e++;
         if (acc) cur++;
         #1;
         if (e == 5) begin
            check("t3_accepted_5", cur - 1, 5);
            check("t3_ready_full", {31'd0, ready0}, 0);
            check("t3_level_full", {29'd0, level0}, 4);
         end
         if (e == 50) begin
            check("t3_still_full_level", {29'd0, level0}, 4);
            check("t3_still_full_ready", {31'd0, ready0}, 0);
         end
         @(negedge clk);
      end
      valid0 = 1'b0;
      check("t3_all_accepted", cur, 7);
      check("t3_accept_edge_of_6", e, 104);
      wait_idle(0);
      check("t3_frames", st0.size(), 6);
      for (int i = 0; i + 1 < st0.size(); i++)
         check($sformatf("t3_gap_%0d", i), 32'(st0[i + 1] - st0[i]), 1010);
      // sustained traffic across pointer wrap
      for (int i = 0; i < 12; i++) begin
         repeat ($urandom_range(0, 40)) @(posedge clk);
         send(0, vec[i]);
      end
      wait_idle(0);
      // reset during DATA bit 3 with two bytes queued
      send(0, 8'h11);
      send(0, 8'h16);
      send(0, 8'h33);
      check("t5_level_queued", {29'd0, level0}, 2);
      repeat (42) @(posedge clk);
      @(negedge clk);
      check("t5_tx_bit3", {31'd0, tx0}, 0);
      skip = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("t5_tx", {31'd0, tx0}, 1);
      check("t5_level", {29'd0, level0}, 0);
      check("t5_busy", {31'd0, busy0}, 0);
      check("t5_ready", {31'd0, ready0}, 1);
      @(negedge clk) rst = 1'b0;
      chg = 0;
      for (int k = 0; k < 150; k++) begin
         @(posedge clk);
         #1 if (tx0 !== 1'b1) chg++;
      end
      check("t5_tx_quiet", chg, 0);
      q0.delete();
      skip = 1'b0;
      // push coincident with the IDLE pop
      send(0, 8'h3C);
      send(0, 8'hC3);
      check("t6_level_stays_1", {29'd0, level0}, 1);
      check("t6_tx_start", {31'd0, tx0}, 0);
      wait_idle(0);
      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
